// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Modular 8-bit running sum used for the image trailer check.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, memory-write and status signals of the loader; slave = loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [6:0]        word_count;
    logic              err;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, err
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, err
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; a word closed early by
// 'last' keeps zeros in its unfilled low bytes.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        data,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              complete
);
    logic [1:0]        idx_r;
    logic [WORD_W-1:0] word_r;
    logic [WORD_W-1:0] word_next_s;

    // Insert the incoming byte into its slot; a fresh word starts from zero.
    always_comb begin
        word_next_s = (idx_r == 2'd0) ? {WORD_W{1'b0}} : word_r;
        case (idx_r)
            2'd0:    word_next_s[31:24] = data;
            2'd1:    word_next_s[23:16] = data;
            2'd2:    word_next_s[15:8]  = data;
            default: word_next_s[7:0]   = data;
        endcase
        complete = accept && ((idx_r == 2'd3) || last);
    end

    assign word = word_next_s;

    // Byte index and partial-word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= 2'd0;
            word_r <= {WORD_W{1'b0}};
        end else if (clear) begin
            idx_r  <= 2'd0;
            word_r <= {WORD_W{1'b0}};
        end else if (accept) begin
            idx_r  <= complete ? 2'd0 : idx_r + 2'd1;
            word_r <= word_next_s;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams bytes into sequential word writes while holding
// the pipeline. Define IMEM_LOADER_CHECKSUM_EN for the trailing checksum byte check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam logic [6:0]        MAX_WORDS_C = 7'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_STEP_C = ADDR_W'(BYTES_PER_WORD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e LAST_STATE_C = ST_CHECK;
`else
    localparam state_e LAST_STATE_C = ST_DONE;
`endif

    state_e            state_r, state_next_s;
    logic              in_ready_r, mem_we_r, cpu_hold_r, done_r, last_word_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] mem_wdata_r, pack_word_s;
    logic [6:0]        word_count_r;
    logic              start_s, accept_s, data_accept_s, pack_complete_s, count_full_s;

    assign start_s       = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign accept_s      = bus.in_valid && in_ready_r;
    assign data_accept_s = accept_s && (state_r == ST_COLLECT);
    assign count_full_s  = (word_count_r + 7'd1) == MAX_WORDS_C;

    imem_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (start_s),
        .accept   (data_accept_s),
        .data     (bus.in_data),
        .last     (bus.in_last),
        .word     (pack_word_s),
        .complete (pack_complete_s)
    );

    // Next-state decision.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    state_next_s = start_s ? ST_COLLECT : ST_IDLE;
            ST_COLLECT: state_next_s = pack_complete_s ? ST_WRITE : ST_COLLECT;
            ST_WRITE:   state_next_s = (last_word_r || count_full_s) ? LAST_STATE_C : ST_COLLECT;
            ST_CHECK:   state_next_s = accept_s ? ST_DONE : ST_CHECK;
            ST_DONE:    state_next_s = start_s ? ST_COLLECT : ST_DONE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // State register; control outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == ST_COLLECT) || (state_next_s == ST_CHECK);
            mem_we_r   <= (state_next_s == ST_WRITE);
            cpu_hold_r <= (state_next_s != ST_DONE);
            done_r     <= (state_next_s == ST_DONE);
        end
    end

    // Address/count advance after each write; packed word captured as it completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r       <= {ADDR_W{1'b0}};
            word_count_r <= 7'd0;
            mem_wdata_r  <= {WORD_W{1'b0}};
            last_word_r  <= 1'b0;
        end else begin
            if (start_s) begin
                addr_r       <= {ADDR_W{1'b0}};
                word_count_r <= 7'd0;
                last_word_r  <= 1'b0;
            end else if (state_r == ST_WRITE) begin
                addr_r       <= addr_r + ADDR_STEP_C;
                word_count_r <= word_count_r + 7'd1;
            end
            if (pack_complete_s) begin
                mem_wdata_r <= pack_word_s;
                last_word_r <= bus.in_last;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_r;
    logic       err_r;
    logic       check_accept_s;

    assign check_accept_s = accept_s && (state_r == ST_CHECK);

    // Running sum of data bytes; the trailer byte is compared against it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r <= 8'd0;
            err_r <= 1'b0;
        end else if (start_s) begin
            sum_r <= 8'd0;
            err_r <= 1'b0;
        end else if (data_accept_s) begin
            sum_r <= sum8(sum_r, bus.in_data);
        end else if (check_accept_s) begin
            err_r <= (bus.in_data != sum_r);
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.cpu_hold   = cpu_hold_r;
    assign bus.done       = done_r;
    assign bus.word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: word packing, padding, gaps, capacity, reset abort
// and (with IMEM_LOADER_CHECKSUM_EN) the trailer check.
module tb_imem_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int TRAILER = 1;
`else
    localparam int TRAILER = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, last_acc_cyc = -10, acc_cnt = 0, ready_bad = 0, lat_bad = 0;
    logic [31:0]       wr_data[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [7:0]        exp_sum;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (bus.mem_we) begin
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_wdata);
                if (bus.in_ready !== 1'b0) ready_bad++;
                if (cyc != last_acc_cyc + 1) lat_bad++;
            end
        end
    end

    task automatic clear_mon();
        wr_data.delete(); wr_addr.delete();
        acc_cnt = 0; ready_bad = 0; lat_bad = 0;
    endtask

    task automatic begin_load();
        clear_mon();
        exp_sum = 8'd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = last;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        if (!ok) begin total_cnt++; $display("FAIL handshake_timeout byte=%h in_ready never 1", b); end
    endtask

    task automatic send_data(input logic [7:0] b, input logic last, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        exp_sum = exp_sum + b;
        send_byte(b, last);
    endtask

    task automatic finish_load(input string tag);
        bit ok = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(exp_sum, 1'b0);
`endif
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin total_cnt++; $display("FAIL %s.done_timeout done=%b want 1", tag, bus.done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.cpu_hold !== 1'b1) $display("FAIL rst.cpu_hold got %b want 1", bus.cpu_hold); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rst.in_ready got %b want 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL rst.mem_we got %b want 0", bus.mem_we); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL rst.done got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL rst.err got %b want 0", bus.err); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 8'h00) $display("FAIL rst.mem_addr got %h want 00", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst.mem_wdata got %h want 0", bus.mem_wdata); else pass_cnt++;
        total_cnt++; if (bus.word_count !== 7'd0) $display("FAIL rst.word_count got %0d want 0", bus.word_count); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_two_words();
        logic [7:0] s [8] = '{8'hE2, 8'h11, 8'h00, 8'h00, 8'hE0, 8'h80, 8'h51, 8'h83};
        begin_load();
        foreach (s[i]) send_data(s[i], i == 7, 1'b0);
        finish_load("two");
        total_cnt++; if (wr_data.size() != 2) $display("FAIL two.writes got %0d want 2", wr_data.size()); else pass_cnt++;
        total_cnt++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hE2110000) $display("FAIL two.w0 got %h@%h want e2110000@00", wr_data[0], wr_addr[0]); else pass_cnt++;
        total_cnt++; if (wr_addr[1] !== 8'h04 || wr_data[1] !== 32'hE0805183) $display("FAIL two.w1 got %h@%h want e0805183@04", wr_data[1], wr_addr[1]); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) $display("FAIL two.done_hold got %b%b want 10", bus.done, bus.cpu_hold); else pass_cnt++;
        total_cnt++; if (bus.word_count !== 7'd2) $display("FAIL two.word_count got %0d want 2", bus.word_count); else pass_cnt++;
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL two.err got %b want 0", bus.err); else pass_cnt++;
        total_cnt++; if (lat_bad != 0 || ready_bad != 0) $display("FAIL two.latency got lat_bad=%0d ready_bad=%0d want 0/0", lat_bad, ready_bad); else pass_cnt++;
    endtask

    task automatic test_partial();
        logic [7:0] s [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h1A, 8'hFF};
        begin_load();
        foreach (s[i]) send_data(s[i], i == 5, 1'b0);
        finish_load("part");
        total_cnt++; if (wr_data.size() != 2) $display("FAIL part.writes got %0d want 2", wr_data.size()); else pass_cnt++;
        total_cnt++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h12345678) $display("FAIL part.w0 got %h@%h want 12345678@00", wr_data[0], wr_addr[0]); else pass_cnt++;
        total_cnt++; if (wr_addr[1] !== 8'h04 || wr_data[1] !== 32'h1AFF0000) $display("FAIL part.w1 got %h@%h want 1aff0000@04", wr_data[1], wr_addr[1]); else pass_cnt++;
        // Single-byte image: one padded word.
        begin_load();
        send_data(8'hC3, 1'b1, 1'b0);
        finish_load("one");
        total_cnt++; if (wr_data.size() != 1 || wr_data[0] !== 32'hC3000000 || wr_addr[0] !== 8'h00) $display("FAIL one.w0 got n=%0d %h want n=1 c3000000@00", wr_data.size(), wr_data[0]); else pass_cnt++;
        total_cnt++; if (bus.word_count !== 7'd1) $display("FAIL one.word_count got %0d want 1", bus.word_count); else pass_cnt++;
    endtask

    task automatic test_gaps();
        logic [7:0] s [12] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h13, 8'h57, 8'h9B, 8'hDF};
        begin_load();
        foreach (s[i]) send_data(s[i], i == 11, 1'b1);
        finish_load("gaps");
        total_cnt++; if (wr_data.size() != 3) $display("FAIL gaps.writes got %0d want 3", wr_data.size()); else pass_cnt++;
        total_cnt++; if (wr_data[0] !== 32'h10325476 || wr_addr[0] !== 8'h00) $display("FAIL gaps.w0 got %h@%h want 10325476@00", wr_data[0], wr_addr[0]); else pass_cnt++;
        total_cnt++; if (wr_data[1] !== 32'h98BADCFE || wr_addr[1] !== 8'h04) $display("FAIL gaps.w1 got %h@%h want 98badcfe@04", wr_data[1], wr_addr[1]); else pass_cnt++;
        total_cnt++; if (wr_data[2] !== 32'h13579BDF || wr_addr[2] !== 8'h08) $display("FAIL gaps.w2 got %h@%h want 13579bdf@08", wr_data[2], wr_addr[2]); else pass_cnt++;
        total_cnt++; if (ready_bad != 0) $display("FAIL gaps.ready_in_write got %0d want 0", ready_bad); else pass_cnt++;
        total_cnt++; if (lat_bad != 0) $display("FAIL gaps.latency got %0d want 0", lat_bad); else pass_cnt++;
    endtask

    task automatic test_capacity();
        int bad = 0;
        logic [31:0] e;
        begin_load();
        for (int i = 0; i < MAX_WORDS * 4; i++) send_data(8'(i), 1'b0, 1'b0);
        finish_load("cap");
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        repeat (20) begin @(posedge clk); #1; end
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL cap.in_ready got %b want 0", bus.in_ready); else pass_cnt++;
        bus.in_valid = 1'b0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            e = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
            if (k >= wr_data.size() || wr_data[k] !== e || wr_addr[k] !== 8'(4 * k)) bad++;
        end
        total_cnt++; if (wr_data.size() != MAX_WORDS) $display("FAIL cap.writes got %0d want %0d", wr_data.size(), MAX_WORDS); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL cap.words got %0d bad want 0", bad); else pass_cnt++;
        total_cnt++; if (acc_cnt != MAX_WORDS * 4 + TRAILER) $display("FAIL cap.accepted got %0d want %0d", acc_cnt, MAX_WORDS * 4 + TRAILER); else pass_cnt++;
        total_cnt++; if (bus.word_count !== 7'd64 || bus.done !== 1'b1) $display("FAIL cap.count_done got %0d/%b want 64/1", bus.word_count, bus.done); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        begin_load();
        for (int i = 0; i < 5; i++) send_data(8'hA1 + 8'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL mid.we_ready got %b%b want 00", bus.mem_we, bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) $display("FAIL mid.hold_done got %b%b want 10", bus.cpu_hold, bus.done); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 8'h00 || bus.word_count !== 7'd0 || bus.mem_wdata !== 32'h0) $display("FAIL mid.regs got %h/%0d/%h want 00/0/0", bus.mem_addr, bus.word_count, bus.mem_wdata); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        total_cnt++; if (wr_data.size() != 1 || wr_data[0] !== 32'hA1A2A3A4) $display("FAIL mid.writes got n=%0d %h want n=1 a1a2a3a4", wr_data.size(), wr_data[0]); else pass_cnt++;
        begin_load();
        foreach (s[i]) send_data(s[i], i == 7, 1'b0);
        finish_load("reload");
        total_cnt++; if (wr_data[0] !== 32'h01234567 || wr_addr[0] !== 8'h00) $display("FAIL reload.w0 got %h@%h want 01234567@00", wr_data[0], wr_addr[0]); else pass_cnt++;
        total_cnt++; if (wr_data[1] !== 32'h89ABCDEF || wr_addr[1] !== 8'h04) $display("FAIL reload.w1 got %h@%h want 89abcdef@04", wr_data[1], wr_addr[1]); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        begin_load();
        send_data(8'hAA, 1'b0, 1'b0);
        send_data(8'hBB, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        send_data(8'hCC, 1'b0, 1'b0);
        send_data(8'hDD, 1'b1, 1'b0);
        finish_load("ign");
        total_cnt++; if (wr_data.size() != 1 || wr_data[0] !== 32'hAABBCCDD || wr_addr[0] !== 8'h00) $display("FAIL ign.w0 got n=%0d %h want n=1 aabbccdd@00", wr_data.size(), wr_data[0]); else pass_cnt++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        begin_load();
        for (int i = 1; i <= 4; i++) send_data(8'(i), i == 4, 1'b0);
        send_byte(8'h0B, 1'b0);
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.err !== 1'b1 || bus.done !== 1'b1) $display("FAIL csum_bad got err=%b done=%b want 1/1", bus.err, bus.done); else pass_cnt++;
        begin_load();
        @(negedge clk);
        total_cnt++; if (bus.err !== 1'b0) $display("FAIL csum_clear got err=%b want 0", bus.err); else pass_cnt++;
        for (int i = 1; i <= 4; i++) send_data(8'(i), i == 4, 1'b0);
        send_byte(8'h0A, 1'b0);
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.err !== 1'b0 || bus.done !== 1'b1) $display("FAIL csum_good got err=%b done=%b want 0/1", bus.err, bus.done); else pass_cnt++;
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        test_reset();
        test_two_words();
        test_partial();
        test_gaps();
        test_capacity();
        test_reset_mid();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
